pipe_stage_skid: RTL

- Parametrised successor of the fixed-width pipeline stage register: one generic stage between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the plain enable with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush.
- Flush inserts a bubble with control fields zeroed.
- Carries a control bundle and a data bundle of configurable width.

---
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional stall counter output enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned DW       = 69,
  parameter int unsigned CW       = 2,
  parameter int unsigned DATA_CLR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] main_ctrl_q, main_ctrl_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic [CW-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          acc, pop;

  // in_ready depends on registered occupancy only, never on out_ready.
  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (DATA_CLR != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (acc && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles the downstream stalls a valid entry; flush leaves it intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
